// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FETCH_TIMEOUT = 15;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FETCH_TIMEOUT - 1);
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JIDX_HI = 25;
  localparam int JIDX_LO = 0;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: sequential pc, branch/jump targets and jump-over-branch redirect select.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jmp,
  input  logic        branch,
  input  logic        branch_taken,
  output logic [31:0] pc_plus4,
  output logic [31:0] redirect_pc
);
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  always_comb begin
    pc_plus4    = pc + 32'd4;
    br_off      = {{14{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};
    br_tgt      = pc + br_off;
    j_tgt       = {pc[31:28], instr[JIDX_HI:JIDX_LO], 2'b00};
    redirect_pc = jmp ? j_tgt : (branch && branch_taken) ? br_tgt : pc;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/REQ/HOLD instruction fetch FSM with pc redirect and fetch timeout.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic        fetchReq,
  output logic [31:0] memAddr,
  output logic        memRead,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instrValid,
  output logic [31:0] pcOut,
  output logic [31:0] linkAddr,
  input  logic        pcWrite,
  input  logic        jmp,
  input  logic        branch,
  input  logic        branchTaken,
  output logic        memFault
);
  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic [31:0]        pc_plus4;
  logic [31:0]        redirect_pc;

  fetch_next_pc u_next_pc (
    .pc          (pc_q),
    .instr       (instr_q),
    .jmp         (jmp),
    .branch      (branch),
    .branch_taken(branchTaken),
    .pc_plus4    (pc_plus4),
    .redirect_pc (redirect_pc)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // A redirect in HOLD lands on the same edge as HOLD->REQ, so the next fetch uses it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (fetchReq) begin
          state_d = REQ;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      REQ: begin
        if (memReady) begin
          state_d = HOLD;
          instr_d = memData;
          pc_d    = pc_plus4;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        pc_d = pcWrite ? redirect_pc : pc_q;
        if (fetchReq) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memRead    = state_q == REQ;
    instrValid = state_q == HOLD;
    memAddr    = pc_q;
    pcOut      = pc_q;
    linkAddr   = pc_q;
    instr      = instr_q;
    opcode     = instr_q[OP_HI:OP_LO];
    memFault   = fault_q;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven per-cycle vectors plus timeout and async-reset sequences.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        fetchReq = 1'b0;
  logic        memReady = 1'b0;
  logic [31:0] memData = '0;
  logic        pcWrite = 1'b0;
  logic        jmp = 1'b0;
  logic        branch = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] memAddr, instr, pcOut, linkAddr;
  logic [5:0]  opcode;
  logic        memRead, instrValid, memFault;
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_unit dut (
    .clock      (clock),
    .resetN     (resetN),
    .fetchReq   (fetchReq),
    .memAddr    (memAddr),
    .memRead    (memRead),
    .memReady   (memReady),
    .memData    (memData),
    .instr      (instr),
    .opcode     (opcode),
    .instrValid (instrValid),
    .pcOut      (pcOut),
    .linkAddr   (linkAddr),
    .pcWrite    (pcWrite),
    .jmp        (jmp),
    .branch     (branch),
    .branchTaken(branchTaken),
    .memFault   (memFault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        fetch_req;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        pc_write;
    logic        jmp;
    logic        branch;
    logic        taken;
    logic        exp_rd;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic rn, fr, rdy, input logic [31:0] d,
                              input logic pw, j, b, t, rd, vld,
                              input logic [31:0] pc, ins, input logic flt);
    vec_t r;
    r.rst_n = rn; r.fetch_req = fr; r.mem_ready = rdy; r.mem_data = d;
    r.pc_write = pw; r.jmp = j; r.branch = b; r.taken = t;
    r.exp_rd = rd; r.exp_vld = vld; r.exp_pc = pc; r.exp_instr = ins; r.exp_fault = flt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, rdy, input logic [31:0] d, input logic pw, j, b, t);
    fetchReq = fr; memReady = rdy; memData = d;
    pcWrite = pw; jmp = j; branch = b; branchTaken = t;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0);
    tbl[1]  = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        0);
    tbl[2]  = mk(1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        0);
    tbl[3]  = mk(1, 0, 1, 32'h8C080004, 0, 0, 0, 0, 0, 1, 32'h4,        32'h8C080004, 0);
    tbl[4]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h4,        32'h8C080004, 0);
    tbl[5]  = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h4,        32'h8C080004, 0);
    tbl[6]  = mk(1, 0, 0, 32'hDEADBEEF, 1, 1, 0, 0, 1, 0, 32'h4,        32'h8C080004, 0);
    tbl[7]  = mk(1, 0, 1, 32'h1000FFFF, 0, 0, 0, 0, 0, 1, 32'h8,        32'h1000FFFF, 0);
    tbl[8]  = mk(1, 0, 0, 32'h0,        1, 0, 1, 1, 0, 1, 32'h4,        32'h1000FFFF, 0);
    tbl[9]  = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h4,        32'h1000FFFF, 0);
    tbl[10] = mk(1, 0, 1, 32'h1000FFFF, 0, 0, 0, 0, 0, 1, 32'h8,        32'h1000FFFF, 0);
    tbl[11] = mk(1, 0, 0, 32'h0,        1, 0, 1, 0, 0, 1, 32'h8,        32'h1000FFFF, 0);
    tbl[12] = mk(1, 0, 0, 32'h0,        0, 1, 0, 0, 0, 1, 32'h8,        32'h1000FFFF, 0);
    tbl[13] = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h8,        32'h1000FFFF, 0);
    tbl[14] = mk(1, 0, 1, 32'h0BFFFFFF, 0, 0, 0, 0, 0, 1, 32'hC,        32'h0BFFFFFF, 0);
    tbl[15] = mk(1, 1, 0, 32'h0,        1, 1, 0, 0, 1, 0, 32'h0FFFFFFC, 32'h0BFFFFFF, 0);
    tbl[16] = mk(1, 0, 1, 32'h0,        0, 0, 0, 0, 0, 1, 32'h10000000, 32'h0,        0);
    tbl[17] = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h10000000, 32'h0,        0);
    tbl[18] = mk(1, 0, 1, 32'h08000010, 0, 0, 0, 0, 0, 1, 32'h10000004, 32'h08000010, 0);
    tbl[19] = mk(1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 32'h10000040, 32'h08000010, 0);
    tbl[20] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0);
    tbl[21] = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        0);
    tbl[22] = mk(1, 0, 1, 32'h1000FFFE, 0, 0, 0, 0, 0, 1, 32'h4,        32'h1000FFFE, 0);
    tbl[23] = mk(1, 0, 0, 32'h0,        1, 0, 1, 1, 0, 1, 32'hFFFFFFFC, 32'h1000FFFE, 0);
    tbl[24] = mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'hFFFFFFFC, 32'h1000FFFE, 0);
    tbl[25] = mk(1, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 32'h0,        32'h12345678, 0);

    #1;
    chk("por_memRead", {31'b0, memRead}, 32'h0);
    chk("por_pc", pcOut, 32'h0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      resetN = tbl[i].rst_n;
      drive(tbl[i].fetch_req, tbl[i].mem_ready, tbl[i].mem_data,
            tbl[i].pc_write, tbl[i].jmp, tbl[i].branch, tbl[i].taken);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_memRead", i), {31'b0, memRead}, {31'b0, tbl[i].exp_rd});
      chk($sformatf("v%0d_instrValid", i), {31'b0, instrValid}, {31'b0, tbl[i].exp_vld});
      chk($sformatf("v%0d_pcOut", i), pcOut, tbl[i].exp_pc);
      chk($sformatf("v%0d_memAddr", i), memAddr, tbl[i].exp_pc);
      chk($sformatf("v%0d_linkAddr", i), linkAddr, tbl[i].exp_pc);
      chk($sformatf("v%0d_instr", i), instr, tbl[i].exp_instr);
      chk($sformatf("v%0d_opcode", i), {26'b0, opcode}, {26'b0, tbl[i].exp_instr[31:26]});
      chk($sformatf("v%0d_memFault", i), {31'b0, memFault}, {31'b0, tbl[i].exp_fault});
    end

    // Fetch timeout after 15 not-ready REQ cycles, sticky fault, cleared by next fetch.
    do_reset();
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("to_enter_req", {31'b0, memRead}, 32'h1);
    @(negedge clock);
    drive(0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    repeat (14) @(posedge clock);
    #1;
    chk("to_wait14_memRead", {31'b0, memRead}, 32'h1);
    chk("to_wait14_fault", {31'b0, memFault}, 32'h0);
    @(posedge clock); #1;
    chk("to_wait15_memRead", {31'b0, memRead}, 32'h0);
    chk("to_wait15_valid", {31'b0, instrValid}, 32'h0);
    chk("to_wait15_fault", {31'b0, memFault}, 32'h1);
    chk("to_wait15_pc", pcOut, 32'h0);
    chk("to_wait15_instr", instr, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("to_sticky_fault", {31'b0, memFault}, 32'h1);
    chk("to_sticky_idle", {31'b0, memRead}, 32'h0);
    @(negedge clock);
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("to_clear_fault", {31'b0, memFault}, 32'h0);
    chk("to_clear_req", {31'b0, memRead}, 32'h1);
    @(negedge clock);
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    repeat (14) @(posedge clock);
    #1;
    chk("to_cnt_restart", {31'b0, memRead}, 32'h1);
    @(negedge clock);
    drive(0, 1, 32'h8C080004, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("to_late_ready_valid", {31'b0, instrValid}, 32'h1);
    chk("to_late_ready_pc", pcOut, 32'h4);
    chk("to_late_ready_fault", {31'b0, memFault}, 32'h0);

    // Asynchronous reset in the middle of a REQ cycle.
    @(negedge clock);
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("ar_in_req", {31'b0, memRead}, 32'h1);
    @(negedge clock);
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    #2 resetN = 1'b0;
    #1;
    chk("ar_memRead", {31'b0, memRead}, 32'h0);
    chk("ar_pc", pcOut, 32'h0);
    chk("ar_instr", instr, 32'h0);
    chk("ar_valid", {31'b0, instrValid}, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock); #1;
    chk("ar_stays_idle", {31'b0, memRead}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
